// File: rtl/stoch_pkg.sv
// stoch_pkg: shared FSM state type and value-width helper; STOCH_DECODE_BIPOLAR_EN selects the signed width
package stoch_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} stoch_decode_state_t;
  function automatic int value_width(input int window_bits);
`ifdef STOCH_DECODE_BIPOLAR_EN
    return window_bits + 2;
`else
    return window_bits + 1;
`endif
  endfunction
endpackage

// File: rtl/stoch_window_counter.sv
// stoch_window_counter: wrapping window counter with clear, enable and last-cycle flag
module stoch_window_counter #(
  parameter int WINDOW_BITS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);
  logic [WINDOW_BITS-1:0] count;
  // count wraps naturally from N-1 to 0
  always_ff @(posedge clk)
    if (rst || clr) count <= '0;
    else if (en) count <= count + 1'b1;
  assign last = &count;
endmodule

// File: rtl/stoch_decode.sv
// stoch_decode: counts ones over a 2^WINDOW_BITS window and holds the result behind valid/ready; STOCH_DECODE_BIPOLAR_EN gives signed 2*ones-N
module stoch_decode import stoch_pkg::*; #(
  parameter int WINDOW_BITS = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic start,
  input  logic abort,
  input  logic a,
  input  logic ready,
  output logic busy,
  output logic valid,
  output logic [value_width(WINDOW_BITS)-1:0] value
);
  localparam int VW = value_width(WINDOW_BITS);
  stoch_decode_state_t state, next;
  logic [WINDOW_BITS:0] ones, ones_next;
  logic [VW-1:0] decoded;
  logic last, en, done;
  assign en = state == ACCUM && !abort;
  assign done = en && last;
  assign ones_next = ones + (WINDOW_BITS+1)'(a);
`ifdef STOCH_DECODE_BIPOLAR_EN
  assign decoded = VW'({ones_next, 1'b0}) - VW'(2 ** WINDOW_BITS);
`else
  assign decoded = ones_next;
`endif
  stoch_window_counter #(.WINDOW_BITS(WINDOW_BITS)) u_win (
    .clk(CLK), .rst(RST), .clr(!en), .en(en), .last(last)
  );
  // ones counter runs only in ACCUM and sits cleared otherwise, so every conversion starts at zero
  always_ff @(posedge CLK)
    if (RST || !en) ones <= '0;
    else ones <= ones_next;
  // next state: abort beats window completion; a handshake with start skips IDLE
  always_comb begin
    next = IDLE;
    if (state == IDLE) next = start ? ACCUM : IDLE;
    else if (state == ACCUM) next = abort ? IDLE : (last ? HOLD : ACCUM);
    else if (state == HOLD) next = ready ? (start ? ACCUM : IDLE) : HOLD;
  end
  // state plus registered status flags
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= next;
      busy  <= next == ACCUM;
      valid <= next == HOLD;
    end
  // result captured only on entry to HOLD, final bit included
  always_ff @(posedge CLK)
    if (RST) value <= '0;
    else if (done) value <= decoded;
endmodule

// File: doc/stoch_decode.md
# stoch_decode

Stochastic-to-binary decoder that sits directly downstream of the stochastic arithmetic stages, such as the saturating subtractor. It counts the 1s in a unipolar bitstream over a fixed window of 2^WINDOW_BITS cycles and presents the count as a binary value. The result is held behind a valid/ready handshake so that a host or register-file stage can read it at its own pace.

## Interface
- WINDOW_BITS, default 8: log2 of the window length; the window is N = 2^WINDOW_BITS cycles.
- CLK  input  1  single clock, rising edge.
- RST  input  1  reset, synchronous and active-high.
- start  input  1  request a new conversion.
- abort  input  1  cancel an in-progress conversion.
- a  input  1  stochastic bitstream, one bit per cycle.
- busy  output  1  high while accumulating.
- valid  output  1  result available.
- ready  input  1  consumer accepts the result.
- value  output  VW  decoded result; VW = WINDOW_BITS+1 unipolar, WINDOW_BITS+2 bipolar (see Configuration).

## Operation
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 → ACCUM; the ones counter and window counter are cleared.
  - Otherwise stay in IDLE.
- ACCUM:
  - Each cycle, the ones counter adds a.
  - The window counter (WINDOW_BITS bits) increments and wraps from N-1 to 0.
  - On the cycle the window counter equals N-1, the FSM goes to HOLD. The final bit of a is included in the count, and value is registered.
  - abort=1 → IDLE immediately. The bit on that cycle is discarded, valid is not raised, and the counters are cleared.
  - abort has priority over window completion.
  - start is ignored in ACCUM.
- HOLD:
  - valid=1 and value is stable until the handshake completes.
  - valid & ready → IDLE.
  - If start=1 on that same handshake cycle, the FSM goes directly to ACCUM. This gives back-to-back conversions with no IDLE bubble.
  - abort is ignored in HOLD.
- Ones counter width is WINDOW_BITS+1, so a count of N fits and the counter can never overflow.
- Unipolar result: value = ones, range 0..N.

## Timing
- Reset values: state=IDLE, busy=0, valid=0, value=0, all counters=0.
- RST forces these values on the next edge from any state. A conversion in progress is lost and no valid is raised.
- Timing of a conversion:
  - start is sampled at edge 0.
  - a is sampled at edges 1..N, exactly N bits.
  - valid rises after edge N.
  - Latency from start to valid is N+1 cycles.
- busy is high exactly for the N ACCUM cycles and is registered.
- valid and value are registered. value changes only on entry to HOLD.
- Throughput: with start held high and ready held high, one result every N+1 cycles.

## Configuration
- STOCH_DECODE_BIPOLAR_EN defined:
  - value is signed two's complement, VW = WINDOW_BITS+2.
  - value = 2·ones − N, range −N..+N. This decodes a bipolar stream in which p=0.5 represents 0.
- STOCH_DECODE_BIPOLAR_EN undefined: value is unsigned ones, VW = WINDOW_BITS+1.
- The FSM, counters and handshake are identical in both modes.

## Structure
- Shared package stoch_pkg contains:
  - typedef enum logic [1:0] stoch_decode_state_t {IDLE, ACCUM, HOLD};
  - the helper function for value width.
- One sub-module, stoch_window_counter. It is a WINDOW_BITS-bit counter with clear, enable and a last (count == N−1) flag. It is reusable by the bitstream generator stages.
- The ones counter, FSM and output register stay in stoch_decode.

## Test plan
- WINDOW_BITS=8, a=1 constantly, start pulsed once:
  - busy is high for 256 cycles.
  - valid rises 257 cycles after start.
  - value=256 (bipolar: +256).
- a=0 constantly → value=0 (bipolar: −256). a alternating 1,0 → value=128 (bipolar: 0).
- ready=0 for 20 cycles after valid → valid and value are held unchanged. ready=1 → valid drops after the next edge.
- start=1 and ready=1 on the handshake cycle → busy=1 on the next cycle, and a second result arrives 256 cycles later with no IDLE cycle.
- abort at ACCUM cycle 100 → IDLE, no valid. A following start with a=1 constantly gives value=256 (counters were cleared).
- RST=1 mid-ACCUM and during HOLD → busy=0, valid=0, value=0 on the next edge. start during ACCUM has no effect on the count.
